spi_slave: RTL and testbench

- SPI slave, mode 3 (CPOL=1, CPHA=1), MSB first, 8-bit frames.
- Fully synchronous to the system clock: SCLK, SS and MOSI are oversampled through synchronizers; SCLK edges are detected in the sysClk domain.
- Each received byte is compared against a match value to drive a status LED.
- Each transmitted reply is the bitwise complement of the previously received byte.

---
 rtl/spi_slave.sv | 122 ++++++++++++
 tb/tb_spi_slave.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave, mode 3 (CPOL=1, CPHA=1), MSB first, 8-bit frames, fully synchronous to sysClk.
// Each received byte is compared against MATCH_BYTE to drive LED1. Each reply is the bitwise
// complement of the previously received byte.
//
// Ports:
//   sysClk   - system clock; all logic on its rising edge
//   usrReset - synchronous active-low reset
//   SCLK     - SPI clock from master, idles high
//   MOSI     - master-out data, changed by the master on SCLK falling edges
//   SS       - slave select, active-low
//   MISO     - slave-out data, high-impedance while SS is deasserted
//   LED1     - high when the last complete byte equalled MATCH_BYTE
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  MATCH_BYTE  = 8'hAA,
    parameter logic [7:0]  RX_INIT     = 8'hAA
) (
    input  logic sysClk,
    input  logic usrReset,
    input  logic SCLK,
    input  logic MOSI,
    input  logic SS,
    output logic MISO,
    output logic LED1
);

    // Synchronizer chains; the newest sample enters at bit 0.
    logic [SYNC_STAGES-1:0] sclkSyncQ;
    logic [SYNC_STAGES-1:0] ssSyncQ;
    logic [SYNC_STAGES-1:0] mosiSyncQ;

    logic       sclkPrevQ;
    logic       ssActivePrevQ;
    logic [2:0] bitCntQ,  bitCntD;
    logic [7:0] rxShiftQ, rxShiftD;
    logic [7:0] txShiftQ, txShiftD;
    logic [7:0] lastRxQ,  lastRxD;
    logic       misoQ,    misoD;
    logic       ledQ,     ledD;

    logic       sclkNow;
    logic       mosiNow;
    logic       ssActive;
    logic       ssStart;
    logic       sclkRise;
    logic       sclkFall;
    logic [7:0] rxByte;

    assign sclkNow  = sclkSyncQ[SYNC_STAGES-1];
    assign mosiNow  = mosiSyncQ[SYNC_STAGES-1];
    assign ssActive = ~ssSyncQ[SYNC_STAGES-1];
    assign ssStart  = ssActive & ~ssActivePrevQ;
    assign sclkRise = ~sclkPrevQ & sclkNow;
    assign sclkFall = sclkPrevQ & ~sclkNow;

    always_ff @(posedge sysClk) begin
        if (!usrReset) begin
            sclkSyncQ     <= '1;
            ssSyncQ       <= '1;
            mosiSyncQ     <= '0;
            sclkPrevQ     <= 1'b1;
            ssActivePrevQ <= 1'b0;
            bitCntQ       <= '0;
            rxShiftQ      <= '0;
            txShiftQ      <= ~RX_INIT;
            lastRxQ       <= RX_INIT;
            misoQ         <= 1'b1;
            ledQ          <= 1'b0;
        end else begin
            sclkSyncQ     <= {sclkSyncQ[SYNC_STAGES-2:0], SCLK};
            ssSyncQ       <= {ssSyncQ[SYNC_STAGES-2:0], SS};
            mosiSyncQ     <= {mosiSyncQ[SYNC_STAGES-2:0], MOSI};
            sclkPrevQ     <= sclkNow;
            ssActivePrevQ <= ssActive;
            bitCntQ       <= bitCntD;
            rxShiftQ      <= rxShiftD;
            txShiftQ      <= txShiftD;
            lastRxQ       <= lastRxD;
            misoQ         <= misoD;
            ledQ          <= ledD;
        end
    end

    always_comb begin
        bitCntD  = bitCntQ;
        rxShiftD = rxShiftQ;
        txShiftD = txShiftQ;
        lastRxD  = lastRxQ;
        misoD    = misoQ;
        ledD     = ledQ;
        rxByte   = {rxShiftQ[6:0], mosiNow};

        // Inactive select masks SCLK edges, so a deassertion coincident with an edge wins.
        if (!ssActive) begin
            bitCntD  = '0;
            rxShiftD = '0;
        end else if (ssStart) begin
            // Present the reply MSB before the first falling edge arrives.
            bitCntD  = '0;
            txShiftD = ~lastRxQ;
            misoD    = ~lastRxQ[7];
        end else if (sclkFall) begin
            // The first fall of a byte re-presents bit 7; fall k presents bit 7-k.
            misoD    = txShiftQ[7];
            txShiftD = {txShiftQ[6:0], 1'b0};
        end else if (sclkRise) begin
            rxShiftD = rxByte;
            bitCntD  = bitCntQ + 3'd1;
            if (bitCntQ == 3'd7) begin
                lastRxD  = rxByte;
                ledD     = (rxByte == MATCH_BYTE);
                bitCntD  = '0;
                // Back-to-back bytes reply with the complement of the byte just received.
                txShiftD = ~rxByte;
            end
        end
    end

    assign MISO = ssActive ? misoQ : 1'bz;
    assign LED1 = ledQ;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed frame table, a reset-mid-byte sequence and
// randomized frames checked against a byte-level model of the reply/LED rules.
module tb_spi_slave;

    localparam int HalfCyc = 8;  // sysClk cycles per SCLK half-period (16 ns clock -> 256 ns SCLK)

    logic sysClk = 1'b0;
    logic usrReset = 1'b0;
    logic SCLK = 1'b1;
    logic MOSI = 1'b0;
    logic SS = 1'b1;
    logic LED1;
    wire  misoLine;

    // A released MISO line reads as the pulled-down level.
    pulldown (misoLine);

    int checks = 0;
    int errors = 0;
    bit ssOpen = 1'b0;

    spi_slave #(
        .SYNC_STAGES(2),
        .MATCH_BYTE (8'hAA),
        .RX_INIT    (8'hAA)
    ) dut (
        .sysClk  (sysClk),
        .usrReset(usrReset),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .SS      (SS),
        .MISO    (misoLine),
        .LED1    (LED1)
    );

    always #8 sysClk = ~sysClk;

    typedef struct {
        logic [7:0] mosiByte;
        int         nBits;
        bit         closeAfter;
        logic [7:0] expReply;
        logic       expLed;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic halfWait();
        repeat (HalfCyc) @(negedge sysClk);
    endtask

    task automatic openSs();
        SS = 1'b0;
        ssOpen = 1'b1;
        halfWait();
    endtask

    task automatic closeSs();
        SS = 1'b1;
        ssOpen = 1'b0;
        halfWait();
    endtask

    task automatic doReset();
        usrReset = 1'b0;
        repeat (4) @(negedge sysClk);
        usrReset = 1'b1;
        @(negedge sysClk);
    endtask

    // Clocks nBits bits in mode 3; MISO is sampled just before each rising edge.
    // ledSeen is LED1 five sysClk cycles after the 8th rise (or at the end of a partial frame).
    task automatic xferBits(input logic [7:0] txByte, input int nBits,
                            output logic [7:0] rxBits, output logic ledSeen);
        rxBits  = '0;
        ledSeen = LED1;
        for (int i = 0; i < nBits; i++) begin
            SCLK = 1'b0;
            MOSI = txByte[7-i];
            halfWait();
            rxBits = {rxBits[6:0], misoLine};
            SCLK = 1'b1;
            if (i == 7) begin
                repeat (5) @(negedge sysClk);
                ledSeen = LED1;
                repeat (HalfCyc - 5) @(negedge sysClk);
            end else begin
                halfWait();
                ledSeen = LED1;
            end
        end
    endtask

    initial begin
        logic [7:0] rx;
        logic       led;
        logic [7:0] lastRxM;
        logic       ledM;
        logic [7:0] b;
        int         n;
        bit         cl;

        vecs[0] = '{mosiByte: 8'hAA, nBits: 8, closeAfter: 1'b1, expReply: 8'h55, expLed: 1'b1};
        vecs[1] = '{mosiByte: 8'hAA, nBits: 8, closeAfter: 1'b0, expReply: 8'h55, expLed: 1'b1};
        vecs[2] = '{mosiByte: 8'h3C, nBits: 8, closeAfter: 1'b1, expReply: 8'h55, expLed: 1'b0};
        vecs[3] = '{mosiByte: 8'h00, nBits: 8, closeAfter: 1'b1, expReply: 8'hC3, expLed: 1'b0};
        vecs[4] = '{mosiByte: 8'hAA, nBits: 4, closeAfter: 1'b1, expReply: 8'hFF, expLed: 1'b0};
        vecs[5] = '{mosiByte: 8'hAA, nBits: 8, closeAfter: 1'b1, expReply: 8'hFF, expLed: 1'b1};

        // Reset, then idle with SCLK toggling and SS high.
        doReset();
        check("reset_led", {7'b0, LED1}, 8'h00);
        check("reset_miso_released", {7'b0, misoLine}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            SCLK = 1'b0;
            MOSI = 1'($urandom);
            halfWait();
            SCLK = 1'b1;
            halfWait();
        end
        check("idle_led", {7'b0, LED1}, 8'h00);
        check("idle_miso_released", {7'b0, misoLine}, 8'h00);

        // Directed frames.
        for (int v = 0; v < 6; v++) begin
            if (!ssOpen) openSs();
            xferBits(vecs[v].mosiByte, vecs[v].nBits, rx, led);
            check($sformatf("vec%0d_reply", v), rx, vecs[v].expReply >> (8 - vecs[v].nBits));
            check($sformatf("vec%0d_led", v), {7'b0, led}, {7'b0, vecs[v].expLed});
            if (vecs[v].closeAfter) begin
                closeSs();
                check($sformatf("vec%0d_miso_released", v), {7'b0, misoLine}, 8'h00);
                check($sformatf("vec%0d_led_hold", v), {7'b0, LED1}, {7'b0, vecs[v].expLed});
            end
        end

        // Reset in the middle of a byte.
        openSs();
        xferBits(8'h5A, 3, rx, led);
        doReset();
        check("midreset_led", {7'b0, LED1}, 8'h00);
        closeSs();
        check("midreset_miso_released", {7'b0, misoLine}, 8'h00);
        openSs();
        xferBits(8'hAA, 8, rx, led);
        check("postreset_reply", rx, 8'h55);
        check("postreset_led", {7'b0, led}, 8'h01);
        closeSs();

        // Randomized frames against the byte-level model.
        lastRxM = 8'hAA;
        ledM    = 1'b1;
        for (int f = 0; f < 40; f++) begin
            b  = ($urandom_range(0, 3) == 0) ? 8'hAA : 8'($urandom);
            n  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
            cl = (n < 8) || ($urandom_range(0, 1) == 1);
            if (!ssOpen) openSs();
            xferBits(b, n, rx, led);
            check($sformatf("rand%0d_reply", f), rx, (~lastRxM) >> (8 - n));
            if (n == 8) begin
                lastRxM = b;
                ledM    = (b == 8'hAA);
            end
            check($sformatf("rand%0d_led", f), {7'b0, led}, {7'b0, ledM});
            if (cl) begin
                closeSs();
                check($sformatf("rand%0d_miso_released", f), {7'b0, misoLine}, 8'h00);
            end
        end
        if (ssOpen) closeSs();
        check("final_led_hold", {7'b0, LED1}, {7'b0, ledM});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
